// File: rtl/edf_deq_sched.sv
// EDF dequeue scheduler: pops the prio_fifo head, checks its absolute deadline against a
// free-running time base and forwards it downstream. Optional: EDF_DROP_EXPIRED_EN drops/counts expired entries.
module edf_deq_sched #(
  parameter int DW       = 16,
  parameter int TICK_DIV = 10,
  parameter int FIFO_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_valid,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_late,
  input  logic          out_ready,
  output logic [DW-1:0] now,
  output logic [15:0]   drop_cnt,
  output logic [2:0]    dbg_state
);
  // Output handshake: a transfer happens on a rising edge where out_valid && out_ready;
  // out_valid/out_data/out_late stay stable until then, and out_ready alone does nothing.
  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW   = (FIFO_LAT > 1) ? $clog2(FIFO_LAT) : 1;
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(TICK_DIV - 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(FIFO_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  state_t          state_q;
  logic [DIVW-1:0] div_q, div_d;
  logic [DW-1:0]   now_q, now_d;
  logic [DW-1:0]   diff;
  logic            late_now;
  logic [DW-1:0]   hold_q;
  logic            late_q;
  logic [WW-1:0]   wait_q;
  logic            fifo_re_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_late_q;
`ifdef EDF_DROP_EXPIRED_EN
  logic [15:0]     drop_q;
`endif

  always_comb begin
    div_d = div_q + DIVW'(1);
    now_d = now_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      now_d = now_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      now_q <= '0;
    end else begin
      div_q <= div_d;
      now_q <= now_d;
    end
  end

  // Wrap-safe: the head is late when (now - head) is strictly positive as a signed DW-bit value.
  assign diff     = now_q - fifo_dout;
  assign late_now = !diff[DW-1] && (diff != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      late_q      <= 1'b0;
      wait_q      <= '0;
      fifo_re_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_late_q  <= 1'b0;
`ifdef EDF_DROP_EXPIRED_EN
      drop_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fifo_valid && !out_valid_q) begin
            fifo_re_q <= 1'b1;
            state_q   <= S_POP;
          end
        end
        S_POP: begin
          fifo_re_q <= 1'b0;
          hold_q    <= fifo_dout;
          late_q    <= late_now;
          wait_q    <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // Sit out the FIFO's head-update latency so fifo_valid is never resampled stale.
          if (wait_q == WAIT_LAST) state_q <= S_CHECK;
          else wait_q <= wait_q + WW'(1);
        end
        S_CHECK: begin
`ifdef EDF_DROP_EXPIRED_EN
          if (late_q) begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            state_q <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= hold_q;
            out_late_q  <= 1'b0;
            state_q     <= S_SEND;
          end
`else
          out_valid_q <= 1'b1;
          out_data_q  <= hold_q;
          out_late_q  <= late_q;
          state_q     <= S_SEND;
`endif
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_re   = fifo_re_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_late  = out_late_q;
  assign now       = now_q;
  assign dbg_state = state_q;
`ifdef EDF_DROP_EXPIRED_EN
  assign drop_cnt  = drop_q;
`else
  assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_edf_deq_sched.sv
// Bench for edf_deq_sched: behavioural FIFO + time-base model, scoreboard of expected transfers.
// A second instance with TICK_DIV=1 reaches the time-base wrap quickly.
`timescale 1ns/1ps
module tb_edf_deq_sched;
  localparam int DW = 16;
  localparam int TD = 10;
  localparam int FL = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fifo_valid, fifo_re, out_valid, out_late, out_ready;
  logic [DW-1:0] fifo_dout, out_data, now;
  logic [15:0]   drop_cnt;
  logic [2:0]    dbg_state;

  logic          rst_w, fv_w, fr_w, ov_w, ol_w, or_w;
  logic [DW-1:0] fd_w, od_w, now_w;
  logic [15:0]   dc_w;
  logic [2:0]    st_w;

  edf_deq_sched #(.DW(DW), .TICK_DIV(TD), .FIFO_LAT(FL)) dut (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
    .out_valid(out_valid), .out_data(out_data), .out_late(out_late), .out_ready(out_ready),
    .now(now), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  edf_deq_sched #(.DW(DW), .TICK_DIV(1), .FIFO_LAT(FL)) dut_w (
    .clk(clk), .rst(rst_w), .fifo_valid(fv_w), .fifo_dout(fd_w), .fifo_re(fr_w),
    .out_valid(ov_w), .out_data(od_w), .out_late(ol_w), .out_ready(or_w),
    .now(now_w), .drop_cnt(dc_w), .dbg_state(st_w)
  );

  // model / scoreboard state
  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];   // {late, data}
  int n_cmp = 0, n_fail = 0;
  int n_cyc = 0, n_w = 0, t_cyc = 0, pend = 0;
  int pops = 0, xfers = 0, exp_drops = 0;
  int last_pop_t = 0, last_rise_t = 0;
  logic [DW-1:0] last_x_data;
  logic last_x_late;
  logic prev_ov = 1'b0;

  function automatic int model_now(input int n);
    return (n / TD) % 65536;
  endfunction

  function automatic logic model_late(input int nowv, input int head);
    int d;
    d = ((nowv - head) % 65536 + 65536) % 65536;
    return (d != 0) && (d < 32768);
  endfunction

  // driver tasks
  task automatic drive_fifo();
    fifo_valid = (fifo_q.size() > 0);
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  task automatic tick();
    logic stall, rst_s, rstw_s, sl, lt;
    logic [DW-1:0] sd;
    logic [DW:0] e;
    if (out_valid && out_ready && !rst) begin
      xfers++;
      last_x_data = out_data;
      last_x_late = out_late;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got late=%b data=%h, required no transfer", out_late, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_late, out_data} !== e) begin
          n_fail++;
          $display("FAIL xfer_data: got late=%b data=%h, required late=%b data=%h",
                   out_late, out_data, e[DW], e[DW-1:0]);
        end
      end
    end
    stall  = out_valid && !out_ready;
    sd     = out_data;
    sl     = out_late;
    rst_s  = rst;
    rstw_s = rst_w;
    @(posedge clk);
    #1;
    t_cyc++;
    n_cyc = rst_s ? 0 : n_cyc + 1;
    n_w   = rstw_s ? 0 : n_w + 1;
    if (stall && !rst_s) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== sd || out_late !== sl) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 out_valid, out_data, out_late, sd, sl);
      end
    end
    if (!rst_s) begin
      n_cmp++;
      if (now !== DW'(model_now(n_cyc))) begin
        n_fail++;
        $display("FAIL now: got %h, required %h", now, DW'(model_now(n_cyc)));
      end
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        fifo_q.delete(0);
        drive_fifo();
      end
    end
    if (fifo_re) begin
      pops++;
      last_pop_t = t_cyc;
      n_cmp++;
      if (!fifo_valid || dbg_state !== 3'd1 || pend != 0) begin
        n_fail++;
        $display("FAIL pop_legal: got fifo_valid=%b state=%0d pend=%0d, required 1/1/0",
                 fifo_valid, dbg_state, pend);
      end
      pend = FL;
      lt = model_late(model_now(n_cyc), int'(fifo_dout));
`ifdef EDF_DROP_EXPIRED_EN
      if (lt) exp_drops++;
      else exp_q.push_back({1'b0, fifo_dout});
`else
      exp_q.push_back({lt, fifo_dout});
`endif
    end
    if (out_valid && !prev_ov) last_rise_t = t_cyc;
    prev_ov = out_valid;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (!(fifo_q.size() == 0 && pend == 0 && exp_q.size() == 0 &&
             dbg_state == 3'd0 && !out_valid) && i < budget) begin
      tick();
      i++;
    end
    n_cmp++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", nm, budget);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    push(16'd40);
    repeat (20) begin
      tick();
      n_cmp++;
      if ({fifo_re, out_valid, out_data, out_late, now, drop_cnt, dbg_state} !== '0) begin
        n_fail++;
        $display("FAIL reset_vals: got re=%b v=%b d=%h l=%b now=%h dc=%h st=%0d, required all 0",
                 fifo_re, out_valid, out_data, out_late, now, drop_cnt, dbg_state);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (fifo_re !== 1'b1) begin
      n_fail++;
      $display("FAIL first_pop: got fifo_re=%b, required 1", fifo_re);
    end
    wait_idle(50, "reset_drain");
  endtask

  task automatic test_basic();
    int p0, x0, i;
    out_ready = 1'b1;
    while (model_now(n_cyc) < 5) tick();
    p0 = pops;
    x0 = xfers;
    push(16'd100);
    i = 0;
    while (!out_valid && i < 20) begin tick(); i++; end
    n_cmp++;
    if (!out_valid || out_data !== 16'd100 || out_late !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_out: got v=%b d=%h l=%b, required v=1 d=0064 l=0", out_valid, out_data, out_late);
    end
    n_cmp++;
    if (last_rise_t - last_pop_t != FL + 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, required %0d", last_rise_t - last_pop_t, FL + 2);
    end
    wait_idle(20, "basic");
    n_cmp++;
    if (pops - p0 != 1 || xfers - x0 != 1) begin
      n_fail++;
      $display("FAIL basic_count: got pops=%0d xfers=%0d, required 1/1", pops - p0, xfers - x0);
    end
  endtask

  task automatic test_backpressure();
    int p0, x0, i;
    out_ready = 1'b0;
    push(16'd200);
    push(16'd201);
    i = 0;
    while (!out_valid && i < 20) begin tick(); i++; end
    p0 = pops;
    repeat (50) tick();
    n_cmp++;
    if (pops != p0 || out_valid !== 1'b1 || out_data !== 16'd200) begin
      n_fail++;
      $display("FAIL bp_hold: got pops=%0d v=%b d=%h, required pops=0 v=1 d=00c8", pops - p0, out_valid, out_data);
    end
    out_ready = 1'b1;
    x0 = xfers;
    tick();
    n_cmp++;
    if (xfers != x0 + 1) begin
      n_fail++;
      $display("FAIL bp_xfer: got %0d transfers, required 1", xfers - x0);
    end
    i = 0;
    while (pops == p0 && i < 20) begin tick(); i++; end
    n_cmp++;
    if (pops != p0 + 1) begin
      n_fail++;
      $display("FAIL bp_resume: got %0d pops, required 1", pops - p0);
    end
    wait_idle(30, "bp");
  endtask

  task automatic test_expiry();
    int x0, d0;
    out_ready = 1'b1;
    while (model_now(n_cyc) < 150) tick();
    x0 = xfers;
    d0 = exp_drops;
    push(16'd120);
    wait_idle(30, "expiry");
`ifdef EDF_DROP_EXPIRED_EN
    n_cmp++;
    if (xfers != x0 || drop_cnt !== 16'(d0 + 1)) begin
      n_fail++;
      $display("FAIL expiry_drop: got xfers=%0d dc=%0d, required 0 / %0d", xfers - x0, drop_cnt, d0 + 1);
    end
`else
    n_cmp++;
    if (xfers != x0 + 1 || last_x_data !== 16'd120 || last_x_late !== 1'b1 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL expiry_fwd: got xfers=%0d d=%h l=%b dc=%0d, required 1 0078 1 0",
               xfers - x0, last_x_data, last_x_late, drop_cnt);
    end
`endif
  endtask

  task automatic test_boundary();
    int x0;
    logic [DW-1:0] h;
    out_ready = 1'b1;
    x0 = xfers;
    h = DW'(model_now(n_cyc + 1));
    push(h);
    wait_idle(30, "boundary");
    n_cmp++;
    if (xfers != x0 + 1 || last_x_data !== h || last_x_late !== 1'b0) begin
      n_fail++;
      $display("FAIL head_eq_now: got xfers=%0d d=%h l=%b, required 1 %h 0", xfers - x0, last_x_data, last_x_late, h);
    end
  endtask

  task automatic test_random();
    int pushed, i, h;
    pushed = 0;
    i = 0;
    while ((pushed < 40 || fifo_q.size() > 0) && i < 4000) begin
      if (pushed < 40 && $urandom_range(0, 3) == 0) begin
        h = int'($urandom_range(0, 40)) - 20 + model_now(n_cyc);
        push(DW'((h + 65536) % 65536));
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      i++;
    end
    out_ready = 1'b1;
    wait_idle(60, "random");
    n_cmp++;
    if (drop_cnt !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL random_drops: got %0d, required %0d", drop_cnt, exp_drops);
    end
  endtask

  task automatic test_midop_reset();
    int i, x0;
    logic saw;
    out_ready = 1'b1;
    push(DW'(model_now(n_cyc) + 50));
    i = 0;
    while (dbg_state !== 3'd2 && i < 10) begin tick(); i++; end
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_drops = 0;
    n_cmp++;
    if (dbg_state !== 3'd0 || now !== '0 || out_valid !== 1'b0 || fifo_re !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got st=%0d now=%h v=%b re=%b, required 0/0/0/0", dbg_state, now, out_valid, fifo_re);
    end
    tick();
    rst = 1'b0;
    x0 = xfers;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    n_cmp++;
    if (saw || xfers != x0) begin
      n_fail++;
      $display("FAIL midop_discard: got out_valid seen=%b xfers=%0d, required 0/0", saw, xfers - x0);
    end
  endtask

  task automatic test_wrap();
    logic seen_ov;
    or_w = 1'b1;
    fv_w = 1'b0;
    rst_w = 1'b0;
    while (n_w < 16'hFFEF) tick();
    fd_w = 16'h0005;
    fv_w = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 12 && !seen_ov; i++) begin
      tick();
      if (fr_w) begin
        fv_w = 1'b0;
        n_cmp++;
        if (now_w !== DW'(n_w % 65536)) begin
          n_fail++;
          $display("FAIL wrap_now: got %h, required %h", now_w, DW'(n_w % 65536));
        end
      end
      if (ov_w) begin
        seen_ov = 1'b1;
        n_cmp++;
        if ({ol_w, od_w} !== {1'b0, 16'h0005}) begin
          n_fail++;
          $display("FAIL wrap_ontime: got l=%b d=%h, required l=0 d=0005", ol_w, od_w);
        end
      end
    end
    n_cmp++;
    if (!seen_ov) begin
      n_fail++;
      $display("FAIL wrap_fwd: got no out_valid, required one");
    end
    while (n_w < 65538) tick();
    fd_w = 16'hFFF8;
    fv_w = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fr_w) fv_w = 1'b0;
      if (ov_w && !seen_ov) begin
        seen_ov = 1'b1;
`ifndef EDF_DROP_EXPIRED_EN
        n_cmp++;
        if ({ol_w, od_w} !== {1'b1, 16'hFFF8}) begin
          n_fail++;
          $display("FAIL wrap_late: got l=%b d=%h, required l=1 d=fff8", ol_w, od_w);
        end
`endif
      end
    end
`ifdef EDF_DROP_EXPIRED_EN
    n_cmp++;
    if (seen_ov || dc_w !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_drop: got ov=%b dc=%0d, required 0/1", seen_ov, dc_w);
    end
`else
    n_cmp++;
    if (!seen_ov || dc_w !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_late_fwd: got ov=%b dc=%0d, required 1/0", seen_ov, dc_w);
    end
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    fifo_valid = 1'b0;
    fifo_dout  = '0;
    out_ready  = 1'b0;
    rst_w = 1'b1;
    fv_w  = 1'b0;
    fd_w  = '0;
    or_w  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_expiry();
    test_boundary();
    test_random();
    test_midop_reset();
    test_wrap();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
